// File: rtl/or1200_vlx_pkg.sv
// Shared types and helpers for the VLX byte store scheduler.
// States, JPEG stuffing constants and big-endian lane select.
package or1200_vlx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        STUFF
    } vlx_st_e;

    localparam logic [7:0] VLX_STUFF_BYTE = 8'hFF;
    localparam logic [7:0] VLX_PAD_BYTE   = 8'h00;

    // Big-endian lanes: byte 0 of a word sits on bits [31:24].
    function automatic logic [3:0] be_sel(input logic [1:0] a);
        return 4'b1000 >> a;
    endfunction

endpackage

// File: rtl/or1200_vlx_byte_fifo.sv
// Small byte FIFO between the VLX packer and the store sequencer.
// Head is presented combinationally; depth must be a power of two.
module or1200_vlx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [7:0]                 wdata,
    input  logic                       pop,
    output logic [7:0]                 rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/or1200_vlx_store_sched.sv
// Drains packed VLX bytes to the dmem store port, one byte per transfer,
// inserting a 0x00 after every 0xFF and handling flush and CPU stall.
module or1200_vlx_store_sched
    import or1200_vlx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    input  logic        flush_i,
    output logic        flush_done_o,
    input  logic        init_addr_we_i,
    input  logic [31:0] init_addr_i,
    output logic [31:0] addr_o,
    output logic        store_req_o,
    output logic [31:0] store_addr_o,
    output logic [31:0] store_dat_o,
    output logic [3:0]  store_sel_o,
    input  logic        store_ack_i,
    output logic        stall_cpu_o,
    output logic        busy_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [7:0]    head;
    logic          push;
    logic          pop;

    vlx_st_e       state;
    logic [7:0]    cur_byte;
    logic [7:0]    dat_q;
    logic [31:0]   addr;
    logic          req_q;
    logic          flush_pend;

    assign push = byte_valid_i & ~full;
    assign pop  = (state == IDLE) & ~empty;

    or1200_vlx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .wdata (byte_i),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign byte_ready_o = ~full;
    assign busy_o       = (state != IDLE) | ~empty;
    assign flush_done_o = flush_pend & empty & (state == IDLE) & ~push;
    assign stall_cpu_o  = flush_pend | (count >= CW'(FIFO_DEPTH - 1));
    assign addr_o       = addr;
    assign store_req_o  = req_q;
    assign store_addr_o = addr;
    assign store_dat_o  = {4{dat_q}};
    assign store_sel_o  = be_sel(addr[1:0]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cur_byte   <= '0;
            dat_q      <= '0;
            addr       <= RESET_ADDR;
            req_q      <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            if (flush_done_o) begin
                flush_pend <= 1'b0;
            end else if (flush_i) begin
                flush_pend <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (init_addr_we_i && !busy_o) begin
                        addr <= init_addr_i;
                    end
                    if (pop) begin
                        cur_byte <= head;
                        dat_q    <= head;
                        req_q    <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (store_ack_i) begin
                        addr  <= addr + 32'd1;
                        req_q <= 1'b0;
                        if (cur_byte == VLX_STUFF_BYTE) begin
                            dat_q <= VLX_PAD_BYTE;
                            state <= STUFF;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                STUFF: begin
                    // Request reopens one cycle after the 0xFF ack.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (store_ack_i) begin
                        addr  <= addr + 32'd1;
                        req_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or1200_vlx_store_sched.sv
// Directed bench for the VLX store scheduler: vector table plus
// hand-written multi-cycle sequences with a delayed-ack responder.
module tb_or1200_vlx_store_sched;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [7:0]  byt;
    logic        ready;
    logic        flush;
    logic        done;
    logic        iwe;
    logic [31:0] iaddr;
    logic [31:0] addr_o;
    logic        req;
    logic [31:0] sadr;
    logic [31:0] sdat;
    logic [3:0]  ssel;
    logic        ack;
    logic        stall;
    logic        busy;

    logic        tb_ack;
    logic        resp_en;
    logic        resp_ack;
    int          resp_delay;
    int          wc;

    logic [31:0] log_adr [$];
    logic [31:0] log_dat [$];
    logic [3:0]  log_sel [$];

    int n_cmp = 0;
    int n_bad = 0;

    assign ack = resp_en ? resp_ack : tb_ack;

    or1200_vlx_store_sched #(
        .FIFO_DEPTH (4),
        .RESET_ADDR (32'h0)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .byte_valid_i   (valid),
        .byte_i         (byt),
        .byte_ready_o   (ready),
        .flush_i        (flush),
        .flush_done_o   (done),
        .init_addr_we_i (iwe),
        .init_addr_i    (iaddr),
        .addr_o         (addr_o),
        .store_req_o    (req),
        .store_addr_o   (sadr),
        .store_dat_o    (sdat),
        .store_sel_o    (ssel),
        .store_ack_i    (ack),
        .stall_cpu_o    (stall),
        .busy_o         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Store-port responder: acks after resp_delay cycles of request.
    initial begin
        resp_ack = 1'b0;
        wc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en && req && !resp_ack) begin
                wc++;
                if (wc >= resp_delay) begin
                    resp_ack = 1'b1;
                    log_adr.push_back(sadr);
                    log_dat.push_back(sdat);
                    log_sel.push_back(ssel);
                    wc = 0;
                end
            end else begin
                resp_ack = 1'b0;
                if (!req) wc = 0;
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        valid;
        logic [7:0]  byt;
        logic        flush;
        logic        iwe;
        logic [31:0] iaddr;
        logic        ack;
        logic        e_req;
        logic [31:0] e_sadr;
        logic [3:0]  e_sel;
        logic [31:0] e_dat;
        logic [31:0] e_addr;
        logic        e_rdy;
        logic        e_stl;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    vec_t vq [$];

    function automatic vec_t mk(
        logic r, logic v, logic [7:0] b, logic f, logic w,
        logic [31:0] ia, logic a, logic q, logic [31:0] sa,
        logic [3:0] se, logic [31:0] d, logic [31:0] ad,
        logic rd, logic st, logic dn, logic bs);
        vec_t t;
        t.rst = r; t.valid = v; t.byt = b; t.flush = f;
        t.iwe = w; t.iaddr = ia; t.ack = a; t.e_req = q;
        t.e_sadr = sa; t.e_sel = se; t.e_dat = d;
        t.e_addr = ad; t.e_rdy = rd; t.e_stl = st;
        t.e_done = dn; t.e_busy = bs;
        return t;
    endfunction

    task automatic check(input string name,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int from, input int to);
        for (int i = from; i < to; i++) begin
            rst    = vq[i].rst;
            valid  = vq[i].valid;
            byt    = vq[i].byt;
            flush  = vq[i].flush;
            iwe    = vq[i].iwe;
            iaddr  = vq[i].iaddr;
            tb_ack = vq[i].ack;
            #1;
            check($sformatf("vec%0d status", i),
                  {req, ready, stall, done, busy, addr_o},
                  {vq[i].e_req, vq[i].e_rdy, vq[i].e_stl,
                   vq[i].e_done, vq[i].e_busy, vq[i].e_addr});
            if (vq[i].e_req)
                check($sformatf("vec%0d store", i),
                      {sadr, ssel, sdat},
                      {vq[i].e_sadr, vq[i].e_sel, vq[i].e_dat});
            @(posedge clk);
            #1;
        end
        rst = 0; valid = 0; flush = 0; iwe = 0; tb_ack = 0;
    endtask

    task automatic wait_log(input int n, input string name);
        int k = 0;
        while (log_adr.size() < n && k < 200) begin
            tick();
            k++;
        end
        check(name, log_adr.size(), n);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        #1;
        while (busy && k < 200) begin
            tick();
            #1;
            k++;
        end
        check(name, busy, 1'b0);
        tick();
    endtask

    int na;
    int base;
    int pulses;
    logic [7:0] bv;

    initial begin
        rst = 1; valid = 0; byt = 0; flush = 0; iwe = 0;
        iaddr = 0; tb_ack = 0; resp_en = 0; resp_delay = 1;

        // Tests 1, 2 and an empty flush, one record per cycle.
        vq.push_back(mk(0,0,8'h00,0,1,32'h1000,0, 0,0,0,0,32'h0,   1,0,0,0));
        vq.push_back(mk(0,1,8'h12,0,0,32'h0,   0, 0,0,0,0,32'h1000,1,0,0,0));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   0, 0,0,0,0,32'h1000,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   0, 1,32'h1000,4'b1000,
                        32'h12121212,32'h1000,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   1, 1,32'h1000,4'b1000,
                        32'h12121212,32'h1000,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   0, 0,0,0,0,32'h1001,1,0,0,0));
        vq.push_back(mk(0,0,8'h00,0,1,32'h2003,0, 0,0,0,0,32'h1001,1,0,0,0));
        vq.push_back(mk(0,1,8'hFF,0,0,32'h0,   0, 0,0,0,0,32'h2003,1,0,0,0));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   0, 0,0,0,0,32'h2003,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   1, 1,32'h2003,4'b0001,
                        32'hFFFFFFFF,32'h2003,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   1, 0,0,0,0,32'h2004,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   0, 1,32'h2004,4'b1000,
                        32'h0,32'h2004,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   1, 1,32'h2004,4'b1000,
                        32'h0,32'h2004,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   0, 0,0,0,0,32'h2005,1,0,0,0));
        vq.push_back(mk(0,0,8'h00,1,0,32'h0,   0, 0,0,0,0,32'h2005,1,0,0,0));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   0, 0,0,0,0,32'h2005,1,1,1,0));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   0, 0,0,0,0,32'h2005,1,0,0,0));
        na = vq.size();
        // Test 6: reset while the stuffing store is requested.
        vq.push_back(mk(0,0,8'h00,0,1,32'h3000,0, 0,0,0,0,32'h1,   1,0,0,0));
        vq.push_back(mk(0,1,8'hFF,0,0,32'h0,   0, 0,0,0,0,32'h3000,1,0,0,0));
        vq.push_back(mk(0,1,8'h77,0,0,32'h0,   0, 0,0,0,0,32'h3000,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   1, 1,32'h3000,4'b1000,
                        32'hFFFFFFFF,32'h3000,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   0, 0,0,0,0,32'h3001,1,0,0,1));
        vq.push_back(mk(1,0,8'h00,0,0,32'h0,   0, 1,32'h3001,4'b0100,
                        32'h0,32'h3001,1,0,0,1));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   1, 0,0,0,0,32'h0,   1,0,0,0));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   1, 0,0,0,0,32'h0,   1,0,0,0));
        vq.push_back(mk(0,0,8'h00,0,0,32'h0,   0, 0,0,0,0,32'h0,   1,0,0,0));

        @(posedge clk);
        #1;
        run_vecs(0, na);

        // Test 3: five back-to-back pushes, ack after three cycles.
        resp_delay = 3;
        resp_en = 1;
        base = log_adr.size();
        for (int i = 0; i < 5; i++) begin
            valid = 1;
            byt = 8'(i + 1);
            #1;
            check($sformatf("t3 ready push%0d", i), ready, 1'b1);
            check($sformatf("t3 stall push%0d", i), stall, (i == 4));
            tick();
        end
        valid = 0;
        #1;
        check("t3 ready at count4", ready, 1'b0);
        check("t3 stall at count4", stall, 1'b1);
        tick();
        wait_log(base + 5, "t3 store count");
        for (int i = 0; i < 5; i++) begin
            bv = 8'(i + 1);
            check($sformatf("t3 store%0d", i),
                  {log_adr[base+i], log_sel[base+i], log_dat[base+i]},
                  {32'h2005 + 32'(i), 4'b1000 >> (i + 1) % 4, {4{bv}}});
        end
        wait_idle("t3 idle");
        check("t3 addr_o", addr_o, 32'h200A);

        // Test 4: FF, 34 then flush (second flush absorbed).
        resp_delay = 1;
        base = log_adr.size();
        valid = 1; byt = 8'hFF; tick();
        byt = 8'h34; tick();
        valid = 0; flush = 1; tick();
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (pulses == 0) check("t4 stall", stall, 1'b1);
            if (done) begin
                pulses++;
                check("t4 done after last ack", log_adr.size(), base + 3);
            end
            tick();
            flush = 0;
        end
        check("t4 done pulses", pulses, 1);
        check("t4 stall released", stall, 1'b0);
        check("t4 store0", {log_adr[base], log_sel[base], log_dat[base]},
              {32'h200A, 4'b0010, 32'hFFFFFFFF});
        check("t4 store1", {log_adr[base+1], log_sel[base+1], log_dat[base+1]},
              {32'h200B, 4'b0001, 32'h00000000});
        check("t4 store2", {log_adr[base+2], log_sel[base+2], log_dat[base+2]},
              {32'h200C, 4'b1000, 32'h34343434});

        // Test 5: init ignored while busy; address wraps to zero.
        base = log_adr.size();
        iwe = 1; iaddr = 32'hFFFFFFFF; tick();
        iwe = 0; valid = 1; byt = 8'hAA; tick();
        byt = 8'hBB; tick();
        valid = 0; iwe = 1; iaddr = 32'h12345678; tick();
        iwe = 0;
        wait_log(base + 2, "t5 store count");
        check("t5 store0", {log_adr[base], log_sel[base], log_dat[base]},
              {32'hFFFFFFFF, 4'b0001, 32'hAAAAAAAA});
        check("t5 store1", {log_adr[base+1], log_sel[base+1], log_dat[base+1]},
              {32'h00000000, 4'b1000, 32'hBBBBBBBB});
        wait_idle("t5 idle");
        check("t5 addr_o", addr_o, 32'h1);
        resp_en = 0;

        run_vecs(na, vq.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
